control_sequencer: RTL and testbench



---
 rtl/control_sequencer_if.sv | 39 +++
 rtl/control_sequencer.sv | 177 +++++++++++++++++
 tb/tb_control_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Control bundle between the hardwired control unit and the datapath.
// The sequencer (master) drives every strobe plus run/state and reads
// back the IR contents; the datapath (slave) drives ir and consumes the
// strobes one-to-one on its like-named control inputs.
//   ir                                         IR register contents
//   PCout Zlowout MDRout Cout BAout Rout       bus drivers
//   MARIn PCIn MDRIn IRIn YIn ZIn RIn IncPC    register enables / PC++
//   Gra Grb Grc                                register-field selects
//   read write                                 memory strobes
//   add subtract andSignal orSignal            ALU operation select
//   run                                        1 unless halted
//   state                                      current state code (debug)
interface control_sequencer_if;
    logic [31:0] ir;
    logic        PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic        MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn, IncPC;
    logic        Gra, Grb, Grc;
    logic        read, write;
    logic        add, subtract, andSignal, orSignal;
    logic        run;
    logic [3:0]  state;

    modport master (
        input  ir,
        output PCout, Zlowout, MDRout, Cout, BAout, Rout,
        output MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn, IncPC,
        output Gra, Grb, Grc, read, write,
        output add, subtract, andSignal, orSignal, run, state
    );

    modport slave (
        output ir,
        input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
        input  MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, RIn, IncPC,
        input  Gra, Grb, Grc, read, write,
        input  add, subtract, andSignal, orSignal, run, state
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired Moore control unit: fetch (T0-T2), decode of ir[31:27], and
// execute steps (T3-T7) for ld/ldi/st/add/sub/and/or/nop/halt.
// Ports:
//   clk  rising-edge system clock
//   clr  asynchronous active-low reset (returns to IDLE, run=1)
//   bus  control_sequencer_if.master: ir in, all strobes/run/state out
// Strobes are decoded from the registered state and the opcode, so they
// follow the state register immediately, including on asynchronous reset.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0000,
        ST_T0   = 4'b0111,
        ST_T1   = 4'b1000,
        ST_T2   = 4'b1001,
        ST_T3   = 4'b1010,
        ST_T4   = 4'b1011,
        ST_T5   = 4'b1100,
        ST_T6   = 4'b1101,
        ST_T7   = 4'b1110,
        ST_HALT = 4'b1111
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11001;

    state_t           state_r;
    logic [OPW-1:0]   opcode_s;
    logic             is_ld_s, is_ldi_s, is_st_s, is_alu_s, is_halt_s;
    logic             is_mem_s, is_exec_s;
    logic             ir_unused_s;

    assign opcode_s    = bus.ir[31:32-OPW];
    assign ir_unused_s = ^bus.ir[31-OPW:0];

    // Opcode class decode; anything unrecognised (including nop) is no-exec.
    always_comb begin
        is_ld_s   = 1'b0;
        is_ldi_s  = 1'b0;
        is_st_s   = 1'b0;
        is_alu_s  = 1'b0;
        is_halt_s = 1'b0;
        case (opcode_s)
            OP_LD:   is_ld_s   = 1'b1;
            OP_LDI:  is_ldi_s  = 1'b1;
            OP_ST:   is_st_s   = 1'b1;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_OR:   is_alu_s  = 1'b1;
            OP_HALT: is_halt_s = 1'b1;
            default: is_alu_s  = 1'b0;
        endcase
    end

    // ld, ldi and st share the T3/T4 effective-address computation.
    assign is_mem_s  = is_ld_s | is_ldi_s | is_st_s;
    assign is_exec_s = is_mem_s | is_alu_s | is_halt_s;

    // State register and transition logic. The T2 branch looks at ir
    // directly, so the IR contents must already reflect the instruction
    // being fetched by the time T2 completes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_T0;
                ST_T0:   state_r <= ST_T1;
                ST_T1:   state_r <= ST_T2;
                ST_T2:   state_r <= is_exec_s ? ST_T3 : ST_T0;
                ST_T3:   state_r <= is_halt_s ? ST_HALT : ST_T4;
                ST_T4:   state_r <= ST_T5;
                ST_T5:   state_r <= (is_ld_s | is_st_s) ? ST_T6 : ST_T0;
                ST_T6:   state_r <= ST_T7;
                ST_T7:   state_r <= ST_T0;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Moore strobe decode: each state asserts only its listed strobes.
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
        bus.Cout  = 1'b0; bus.BAout   = 1'b0; bus.Rout   = 1'b0;
        bus.MARIn = 1'b0; bus.PCIn    = 1'b0; bus.MDRIn  = 1'b0;
        bus.IRIn  = 1'b0; bus.YIn     = 1'b0; bus.ZIn    = 1'b0;
        bus.RIn   = 1'b0; bus.IncPC   = 1'b0;
        bus.Gra   = 1'b0; bus.Grb     = 1'b0; bus.Grc    = 1'b0;
        bus.read  = 1'b0; bus.write   = 1'b0;
        bus.add   = 1'b0; bus.subtract = 1'b0;
        bus.andSignal = 1'b0; bus.orSignal = 1'b0;
        case (state_r)
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARIn = 1'b1;
                bus.IncPC = 1'b1; bus.ZIn   = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1; bus.PCIn  = 1'b1;
                bus.read    = 1'b1; bus.MDRIn = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRIn = 1'b1;
            end
            ST_T3: begin
                // Base+displacement for memory ops, rb operand otherwise.
                if (is_mem_s) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.YIn = 1'b1;
                end else if (is_alu_s) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.YIn = 1'b1;
                end else begin
                    bus.YIn = 1'b0;
                end
            end
            ST_T4: begin
                if (is_mem_s) begin
                    bus.Cout = 1'b1; bus.add = 1'b1; bus.ZIn = 1'b1;
                end else if (is_alu_s) begin
                    bus.Grc       = 1'b1; bus.Rout = 1'b1; bus.ZIn = 1'b1;
                    bus.add       = (opcode_s == OP_ADD);
                    bus.subtract  = (opcode_s == OP_SUB);
                    bus.andSignal = (opcode_s == OP_AND);
                    bus.orSignal  = (opcode_s == OP_OR);
                end else begin
                    bus.ZIn = 1'b0;
                end
            end
            ST_T5: begin
                // ld/st send the address to MAR; ldi and ALU ops write ra.
                if (is_ld_s | is_st_s) begin
                    bus.Zlowout = 1'b1; bus.MARIn = 1'b1;
                end else if (is_ldi_s | is_alu_s) begin
                    bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.RIn = 1'b1;
                end else begin
                    bus.Zlowout = 1'b0;
                end
            end
            ST_T6: begin
                if (is_ld_s) begin
                    bus.read = 1'b1; bus.MDRIn = 1'b1;
                end else if (is_st_s) begin
                    // read stays low so MDR captures ra from the bus.
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRIn = 1'b1;
                end else begin
                    bus.MDRIn = 1'b0;
                end
            end
            ST_T7: begin
                if (is_ld_s) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.RIn = 1'b1;
                end else if (is_st_s) begin
                    bus.write = 1'b1;
                end else begin
                    bus.write = 1'b0;
                end
            end
            default: bus.PCout = 1'b0;
        endcase
    end

    assign bus.run   = (state_r != ST_HALT);
    assign bus.state = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    logic clk;
    logic clr;
    int   total;
    int   bad;

    control_sequencer_if bus ();

    control_sequencer #(.OPW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions of the packed strobe vector (bit 23 = run).
    localparam logic [23:0] PCOUT = 24'h000001, ZLOWOUT = 24'h000002, MDROUT = 24'h000004;
    localparam logic [23:0] COUT  = 24'h000008, BAOUT   = 24'h000010, ROUT   = 24'h000020;
    localparam logic [23:0] MARIN = 24'h000040, PCIN    = 24'h000080, MDRIN  = 24'h000100;
    localparam logic [23:0] IRIN  = 24'h000200, YIN     = 24'h000400, ZIN    = 24'h000800;
    localparam logic [23:0] RIN   = 24'h001000, INCPC   = 24'h002000, GRA    = 24'h004000;
    localparam logic [23:0] GRB   = 24'h008000, GRC     = 24'h010000, READ   = 24'h020000;
    localparam logic [23:0] WRITE = 24'h040000, ADD     = 24'h080000, SUB    = 24'h100000;
    localparam logic [23:0] AND   = 24'h200000, OR      = 24'h400000, RUN    = 24'h800000;

    typedef struct packed {
        logic [3:0]  st;
        logic [23:0] vec;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [23:0] obs_vec();
        return {bus.run, bus.orSignal, bus.andSignal, bus.subtract, bus.add,
                bus.write, bus.read, bus.Grc, bus.Grb, bus.Gra, bus.IncPC,
                bus.RIn, bus.ZIn, bus.YIn, bus.IRIn, bus.MDRIn, bus.PCIn,
                bus.MARIn, bus.Rout, bus.BAout, bus.Cout, bus.MDRout,
                bus.Zlowout, bus.PCout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [23:0] vec);
        exp_t e;
        e.st  = st;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle behaviour of one whole instruction, fetch included.
    task automatic push_instr(input logic [31:0] ir_val);
        logic [4:0]  op;
        logic [23:0] alu;
        op = ir_val[31:27];
        push(4'b0111, PCOUT | MARIN | INCPC | ZIN | RUN);
        push(4'b1000, ZLOWOUT | PCIN | READ | MDRIN | RUN);
        push(4'b1001, MDROUT | IRIN | RUN);
        case (op)
            5'b00000, 5'b00001, 5'b00010: begin
                push(4'b1010, GRB | BAOUT | YIN | RUN);
                push(4'b1011, COUT | ADD | ZIN | RUN);
                if (op == 5'b00001) begin
                    push(4'b1100, ZLOWOUT | GRA | RIN | RUN);
                end else begin
                    push(4'b1100, ZLOWOUT | MARIN | RUN);
                    if (op == 5'b00000) begin
                        push(4'b1101, READ | MDRIN | RUN);
                        push(4'b1110, MDROUT | GRA | RIN | RUN);
                    end else begin
                        push(4'b1101, GRA | ROUT | MDRIN | RUN);
                        push(4'b1110, WRITE | RUN);
                    end
                end
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                alu = (op == 5'b00011) ? ADD : (op == 5'b00100) ? SUB :
                      (op == 5'b00101) ? AND : OR;
                push(4'b1010, GRB | ROUT | YIN | RUN);
                push(4'b1011, GRC | ROUT | ZIN | alu | RUN);
                push(4'b1100, ZLOWOUT | GRA | RIN | RUN);
            end
            5'b11001: push(4'b1010, RUN);
            default: ;
        endcase
    endtask

    // Pop and compare up to n expected cycles, sampling on the falling edge.
    task automatic drain(input string tag, input logic [31:0] ir_val, input int n);
        exp_t        e;
        logic [23:0] v;
        logic        inv_ok;
        int          k;
        k = 0;
        while (exp_q.size() > 0 && k < n) begin
            @(negedge clk);
            if (k == 0) bus.ir = ir_val;
            e = exp_q.pop_front();
            v = obs_vec();
            check($sformatf("%s.state[%0d]", tag, k), {28'd0, bus.state}, {28'd0, e.st});
            check($sformatf("%s.strobes[%0d]", tag, k), {8'd0, v}, {8'd0, e.vec});
            inv_ok = ($countones(v[5:0]) <= 1) && ($countones(v[22:19]) <= 1) && !(v[17] && v[18]);
            check($sformatf("%s.onehot[%0d]", tag, k), {31'd0, inv_ok}, 32'd1);
            k++;
        end
    endtask

    task automatic exec(input string tag, input logic [31:0] ir_val);
        push_instr(ir_val);
        drain(tag, ir_val, 1000);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clr    = 1'b0;
        bus.ir = 32'h0000_0000;
        @(negedge clk);
        @(negedge clk);
        check("reset.state", {28'd0, bus.state}, 32'd0);
        check("reset.strobes", {8'd0, obs_vec()}, {8'd0, RUN});
        clr = 1'b1;

        exec("ldi", 32'h0880_0015);
        exec("add", 32'h1891_8000);
        exec("sub", 32'h2091_8000);
        exec("and", 32'h2891_8000);
        exec("or",  32'h3091_8000);
        exec("ld",  32'h0080_0010);
        exec("st",  32'h1080_0010);
        exec("nop", 32'hC000_0000);
        exec("ill1f", 32'hF800_0000);
        exec("ill07", 32'h3800_0000);

        // Reset asserted in T4 of an add: IDLE within the same cycle.
        push_instr(32'h1891_8000);
        drain("addrst", 32'h1891_8000, 5);
        clr = 1'b0;
        #1;
        check("midrst.state", {28'd0, bus.state}, 32'd0);
        check("midrst.strobes", {8'd0, obs_vec()}, {8'd0, RUN});
        exp_q.delete();
        @(negedge clk);
        check("midrst.hold", {28'd0, bus.state}, 32'd0);
        clr = 1'b1;
        @(negedge clk);
        check("rel.t0", {28'd0, bus.state}, 32'h7);
        @(negedge clk);
        check("rel.t1", {28'd0, bus.state}, 32'h8);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        exec("ldi2", 32'h0880_0015);

        // halt parks in HALT with run low until clr.
        push_instr(32'hC800_0000);
        for (int i = 0; i < 20; i++) push(4'b1111, 24'h000000);
        drain("halt", 32'hC800_0000, 1000);
        clr = 1'b0;
        #1;
        check("haltrst.state", {28'd0, bus.state}, 32'd0);
        check("haltrst.strobes", {8'd0, obs_vec()}, {8'd0, RUN});
        @(negedge clk);
        clr = 1'b1;
        exec("nop2", 32'hC000_0000);
        @(negedge clk);
        check("final.t0", {28'd0, bus.state}, 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
